// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the PCM frame packer.
//   WORD_W / SEQ_W  : serial word width and header sequence field width
//   SYNC_DEFAULT    : default header sync byte
//   state_e         : packer FSM states
//   hdr_pack()      : builds the header word {sync, seq}
package frame_pkg;

  localparam int WORD_W = 16;
  localparam int SEQ_W  = 8;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    CKSUM = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] hdr_pack(input logic [7:0]       sync,
                                                 input logic [SEQ_W-1:0] seq);
    return {sync, seq};
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: single-clock frame FIFO; one entry holds a whole frame
// ({seq, channel data}). The head entry is presented combinationally.
// A push and a pop in the same cycle are both honoured, including when full:
// the push lands in the slot the pop is vacating and the count stays at DEPTH.
// Ports:
//   CLKDIVH2, RST : clock, async active-high reset
//   push_i, din_i : write strobe / entry to write (caller guarantees !full || pop)
//   pop_i         : retire the head entry (caller guarantees !empty)
//   head_o        : current head entry
//   full_o, empty_o, count_o : occupancy
module frame_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       CLKDIVH2,
  input  logic                       RST,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge CLKDIVH2 or posedge RST) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge CLKDIVH2) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/pcm_frame_packer.sv
// pcm_frame_packer: captures one multichannel PCM sample set per in_valid into
// a frame FIFO and streams each frame as 16-bit words over valid/ready:
// header {SYNC, seq}, then channel 0..NCH-1, then (FRAME_CKSUM_EN only) a
// 16-bit mod-2^16 sum of the header and channel words.
// Build option: define FRAME_CKSUM_EN to append the checksum word.
// Ports:
//   CLKDIVH2, RST       : clock, async active-high reset
//   in_valid, in_data   : one frame of NCH x 16-bit samples (channel k at [16k+15:16k])
//   out_ready           : downstream accepts the current word
//   out_valid, out_data : serial word stream
//   out_last            : final word of the frame
//   overflow, drop_cnt  : sticky drop flag, saturating dropped-frame count
//
// state | meaning
// IDLE  | nothing to send, waiting for a stored frame
// HDR   | presenting header {SYNC, seq} of the head frame
// DATA  | presenting channel idx of the head frame
// CKSUM | presenting the frame checksum (FRAME_CKSUM_EN only)
module pcm_frame_packer
  import frame_pkg::*;
#(
  parameter int         NCH   = 2,
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
  input  logic                    CLKDIVH2,
  input  logic                    RST,
  input  logic                    in_valid,
  input  logic [NCH*WORD_W-1:0]   in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam int IDX_W = $clog2(NCH) + 1;
  localparam int FW    = NCH*WORD_W + SEQ_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH-1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEQ_W-1:0]  seq_q;
  logic              overflow_q;
  logic [7:0]        drop_q;

  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [FW-1:0]     fifo_head;
  logic              push, pop, xfer, frame_remains;

  logic [WORD_W-1:0] ch_word [NCH];
  logic [WORD_W-1:0] cur_word, hdr_word;

  frame_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .CLKDIVH2 (CLKDIVH2),
    .RST      (RST),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    ({seq_q, in_data}),
    .head_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch_word[k] = fifo_head[k*WORD_W +: WORD_W];
  end

  assign hdr_word = hdr_pack(SYNC, fifo_head[FW-1 -: SEQ_W]);

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) cur_word = ch_word[k];
    end
  end

`ifdef FRAME_CKSUM_EN
  logic [WORD_W-1:0] cksum_word;

  always_comb begin
    cksum_word = hdr_word;
    for (int k = 0; k < NCH; k++) cksum_word = cksum_word + ch_word[k];
  end
`endif

  // Outputs depend on state and the stable head entry only, so they hold
  // while stalled and a mid-frame write cannot disturb the frame in flight.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = cur_word;
`ifndef FRAME_CKSUM_EN
        out_last  = (idx_q == LAST_IDX);
`endif
      end
`ifdef FRAME_CKSUM_EN
      CKSUM: begin
        out_valid = 1'b1;
        out_data  = cksum_word;
        out_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign xfer = out_valid && out_ready;
  assign pop  = xfer && out_last;
  // A pop frees a slot in the same cycle, so a write at full still lands.
  assign push = in_valid && (!fifo_full || pop);
  // Only meaningful on the pop cycle: is anything left for a bubble-free HDR?
  assign frame_remains = push || (fifo_count > CNT_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = HDR;
      HDR: begin
        if (xfer) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
`ifdef FRAME_CKSUM_EN
            state_d = CKSUM;
`else
            state_d = frame_remains ? HDR : IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FRAME_CKSUM_EN
      CKSUM: if (xfer) state_d = frame_remains ? HDR : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKDIVH2 or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // seq advances on dropped frames too, exposing gaps to the host.
      if (in_valid) seq_q <= seq_q + 1'b1;
      if (in_valid && !push) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
module tb_pcm_frame_packer;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;
`ifdef FRAME_CKSUM_EN
  localparam int NW = 6;
  localparam bit CK = 1'b1;
`else
  localparam int NW = 5;
  localparam bit CK = 1'b0;
`endif

  logic          CLKDIVH2 = 1'b0;
  logic          RST;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          out_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_last;
  logic          overflow;
  logic [7:0]    drop_cnt;

  int            tests = 0;
  int            fails = 0;
  logic [7:0]    seq_m;
  logic [7:0]    s0;

  pcm_frame_packer #(.NCH(NCH), .DEPTH(DEPTH), .SYNC(8'hA5)) dut (
    .CLKDIVH2  (CLKDIVH2),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 CLKDIVH2 = ~CLKDIVH2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKDIVH2);
    #1;
  endtask

  function automatic logic [63:0] fd(input int i);
    logic [15:0] b;
    b = 16'(i);
    return {16'h3000 + b, 16'h2000 + b, 16'h1000 + b, b};
  endfunction

  task automatic write(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    seq_m++;
  endtask

  // Wait (bounded) for a word, check it, then accept it on the next edge.
  task automatic recv(input string tag, input logic [15:0] d, input logic l);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_last"},  32'(out_last),  32'(l));
    out_ready = 1'b1;
    tick();
  endtask

  // Receives a whole frame; optionally strobes a new frame in on the last word.
  task automatic recv_frame(input logic [7:0] s, input logic [63:0] d,
                            input bit strobe, input logic [63:0] nd);
    logic [15:0] w [6];
    logic [15:0] sum;
    w[0] = {8'hA5, s};
    sum  = w[0];
    for (int k = 0; k < 4; k++) begin
      w[k+1] = d[16*k +: 16];
      sum    = sum + w[k+1];
    end
    w[5] = sum;
    for (int i = 0; i < NW; i++) begin
      if (strobe && i == NW-1) begin
        in_valid = 1'b1;
        in_data  = nd;
        seq_m++;
      end
      recv($sformatf("f%02h_w%0d", s, i), w[i], (i == NW-1));
      in_valid = 1'b0;
    end
  endtask

  initial begin
    RST       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    seq_m     = '0;

    // Reset state
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    check("rst_drop",  32'(drop_cnt),  32'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Single frame, latency and exact words
    out_ready = 1'b1;
    write(64'h7FFF_8000_FFFF_0001);
    check("lat_t0_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_t1_valid", 32'(out_valid), 32'd1);
    recv("s_hdr", 16'hA500, 1'b0);
    recv("s_c0",  16'h0001, 1'b0);
    recv("s_c1",  16'hFFFF, 1'b0);
    recv("s_c2",  16'h8000, 1'b0);
    recv("s_c3",  16'h7FFF, !CK);
    if (CK) recv("s_ck", 16'hA4FF, 1'b1);
    check("s_idle", 32'(out_valid), 32'd0);

    // Backpressure during DATA idx=1
    write(64'h7FFF_8000_FFFF_0001);
    recv("b_hdr", 16'hA501, 1'b0);
    recv("b_c0",  16'h0001, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b_hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("b_hold%0d_data", i),  32'(out_data),  32'h0000FFFF);
      check($sformatf("b_hold%0d_last", i),  32'(out_last),  32'd0);
    end
    recv("b_c1", 16'hFFFF, 1'b0);
    recv("b_c2", 16'h8000, 1'b0);
    recv("b_c3", 16'h7FFF, !CK);
    if (CK) recv("b_ck", 16'hA500, 1'b1);
    check("b_idle", 32'(out_valid), 32'd0);

    // Reset mid-frame
    write(fd(9));
    recv("rm_hdr", 16'hA502, 1'b0);
    recv("rm_c0",  16'h0009, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("rm_valid", 32'(out_valid), 32'd0);
    check("rm_data",  32'(out_data),  32'd0);
    check("rm_last",  32'(out_last),  32'd0);
    tick();
    tick();
    RST   = 1'b0;
    seq_m = '0;
    tick();
    check("rm_idle", 32'(out_valid), 32'd0);

    // Overflow: six strobes into a stalled four-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) write(fd(i));
    check("ov_flag", 32'(overflow), 32'd1);
    check("ov_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) recv_frame(8'(i), fd(i), 1'b0, '0);
    check("ov_empty", 32'(out_valid), 32'd0);

    // Push at full coincident with the last-word handshake
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write(fd(16 + i));
    check("pf_drop_pre", 32'(drop_cnt), 32'd2);
    recv_frame(8'd6, fd(16), 1'b1, fd(20));
    check("pf_drop",     32'(drop_cnt),  32'd2);
    check("pf_nobubble", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) recv_frame(8'(7 + i), fd(17 + i), 1'b0, '0);
    check("pf_empty", 32'(out_valid), 32'd0);

    // Sequence wrap: 256 frames streamed, crossing A5FF -> A500
    for (int n = 0; n < 256; n++) begin
      s0 = seq_m;
      write(fd(n));
      recv_frame(s0, fd(n), 1'b0, '0);
    end
    check("wrap_seq", 32'(seq_m), 32'd11);

    // drop_cnt saturation: 4 stored, then 300 drops
    out_ready = 1'b0;
    s0 = seq_m;
    for (int i = 0; i < 204; i++) write(fd(i));
    check("sat_mid", 32'(drop_cnt), 32'd202);
    for (int i = 204; i < 304; i++) write(fd(i));
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_ovf",  32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) recv_frame(s0 + 8'(i), fd(i), 1'b0, '0);
    check("sat_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcm_frame_packer.md
Name: pcm_frame_packer

Overview:
- Final stage of each microphone decimation chain, directly downstream of the 16-bit FIR compensation outputs.
- Runs in the 48.828 kHz CLKDIVH2 domain.
- Captures one parallel multichannel PCM sample set per input strobe into a frame FIFO.
- Emits each frame as a serial stream of 16-bit words over a valid/ready interface toward the host/beamformer link. Each frame is a header with a sequence number, then the channel words.

Parameters:
- NCH, 2, number of channels per frame (1..32)
- DEPTH, 4, frame FIFO depth in frames (power of 2, >=2)
- SYNC, 8'hA5, header sync byte

Ports:
- CLKDIVH2  in  1  block clock (decimated output rate)
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  one frame of samples present on in_data this cycle
- in_data  in  NCH*16  channel k in bits [16k+15:16k], two's complement
- out_ready  in  1  downstream accepts out_data this cycle
- out_valid  out  1  out_data holds a valid word
- out_data  out  16  header/channel/checksum word
- out_last  out  1  final word of the current frame
- overflow  out  1  sticky; a frame was dropped since reset
- drop_cnt  out  8  dropped-frame count, saturates at 255

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_last=0, overflow=0, drop_cnt=0.
  - FIFO empty, seq=0, FSM=IDLE.
  - A partially sent frame is abandoned, not resumed.
- Sequence counter seq[7:0]:
  - Increments on every in_valid, whether accepted or dropped. Wraps 255->0.
  - Stored with the frame at write time, so the host detects gaps.
- Write rule:
  - Accept when in_valid && (!full || pop), where pop = frame's last-word handshake in the same cycle.
  - Otherwise drop: set overflow=1, drop_cnt+=1 with saturation.
  - FIFO contents are unchanged on a drop.
- Word transfer happens when out_valid && out_ready.
- While out_valid && !out_ready, out_data and out_last are held stable.
- FSM states:
  - IDLE: out_valid=0. If FIFO not empty at a clock edge, go to HDR.
  - HDR: out_valid=1, out_data={SYNC, seq_of_head_frame}. On transfer, go to DATA with idx=0.
  - DATA: out_data = channel idx of the head frame, channel 0 first. On transfer, idx+=1. On transfer at idx=NCH-1 (out_last=1 here when the optional feature is off):
    - pop the head frame;
    - go to HDR if another frame remains after the pop, else IDLE.
    - There is no bubble between back-to-back frames.
- Latency:
  - Frame written at edge t with FIFO previously empty and FSM in IDLE.
  - out_valid rises after edge t+1, with the header on out_data.
  - Minimum frame duration is NCH+1 cycles.
- Width rules:
  - Data words pass bit-exact.
  - Header seq field is 8 bits.
  - idx is $clog2(NCH)+1 bits wide.
- A write in the same cycle as a pop at full: accepted; count stays at DEPTH.
- A write while the FSM is mid-frame has no effect on the frame being sent.

Optional Feature:
- Macro: FRAME_CKSUM_EN.
- Defined:
  - Adds state CKSUM after DATA.
  - out_data = 16-bit sum mod 2^16 of the header word and all NCH channel words.
  - out_last asserts on the checksum word only.
  - Pop occurs on the checksum transfer.
  - Frame length is NCH+2 words.
- Undefined: no CKSUM state; out_last on the channel NCH-1 word; frame length NCH+1.

Decomposition:
- Package frame_pkg:
  - sync byte default;
  - state enum (IDLE, HDR, DATA, CKSUM);
  - WORD_W=16, SEQ_W=8;
  - header-pack function.
- Sub-module frame_fifo: single-clock FIFO, width NCH*16+8, depth DEPTH.
  - Ports: push, pop, full, empty, head.
  - Supports simultaneous push/pop at full.

Test Plan (NCH=4, DEPTH=4):
- Reset check:
  - Stimulus: assert RST mid-frame.
  - Required: out_valid=0 and out_data=0 immediately; after release, the first header is A5_00.
- Single frame:
  - Stimulus: one in_valid with channels {0x0001,0xFFFF,0x8000,0x7FFF}, out_ready=1.
  - Required: out_valid is high one cycle after the write. Words are A500, 0001, FFFF, 8000, 7FFF, with out_last on 7FFF. With FRAME_CKSUM_EN, out_last is instead on an extra word 0xA4FF.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles during DATA idx=1.
  - Required: out_data holds the word 0xFFFF, then the stream resumes with no loss or duplication.
- Overflow:
  - Stimulus: out_ready=0 with 6 in_valid strobes.
  - Required: 4 frames stored, overflow=1, drop_cnt=2. Draining yields headers A500, A501, A502, A503.
- Push at full with pop:
  - Stimulus: FIFO full and in_valid coincident with the last-word handshake.
  - Required: the frame is accepted and drop_cnt is unchanged.
- Wrap and saturation:
  - Stimulus: 256 frames streamed.
  - Required: the header after A5FF is A500.
  - Stimulus: 300 drops.
  - Required: drop_cnt=255.
